// File: rtl/bsg_tag_packet_decoder.sv
// Serial tag packet decoder.
// Consumes one bit per enabled cycle from a tag bitstream, frames packets of the
// form {start=1, node id, data_not_reset, len, payload} (all fields LSB first),
// and presents each completed packet on a valid/ready output holding register.
// A run of reset_run_p consecutive ones is a line reset: it aborts whatever
// packet is being framed and forces the framer to wait for a zero.
// Reset assertion is asynchronous; deassertion is expected to arrive already
// aligned to clk_i so the first bit is taken on the first edge after release.
module bsg_tag_packet_decoder #(
    parameter int lg_els_p            = 9,
    parameter int lg_width_p          = 4,
    parameter int max_payload_width_p = 10,
    parameter int reset_run_p         = 64
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           en_i,
    input  logic                           data_i,
    output logic                           v_o,
    input  logic                           ready_i,
    output logic [lg_els_p-1:0]            node_id_o,
    output logic                           data_not_reset_o,
    output logic [lg_width_p-1:0]          len_o,
    output logic [max_payload_width_p-1:0] payload_o,
    output logic                           line_reset_o,
    output logic                           overflow_o,
    output logic                           error_o
);

    // Largest length value the len field can carry.
    localparam int max_len = (1 << lg_width_p) - 1;
    // The field counter must index every id bit and every payload bit.
    localparam int cnt_max = (lg_els_p > max_len) ? lg_els_p : max_len;
    localparam int cnt_w   = $clog2(cnt_max + 1);
    localparam int run_w   = $clog2(reset_run_p + 1);

    typedef enum logic [2:0] {
        WAIT_ZERO = 3'd0,
        IDLE      = 3'd1,
        ID        = 3'd2,
        DNR       = 3'd3,
        LEN       = 3'd4,
        PAYLOAD   = 3'd5
    } state_t;

    state_t state;
    state_t state_next;

    logic [cnt_w-1:0] cnt;
    logic [run_w-1:0] ones;

    // Packet under construction.
    logic [lg_els_p-1:0]            id_sh;
    logic                           dnr_sh;
    logic [lg_width_p-1:0]          len_sh;
    logic [max_payload_width_p-1:0] pay_sh;

    // Shadow fields with the bit consumed this cycle already merged in.
    logic [lg_width_p-1:0]          len_full;
    logic [max_payload_width_p-1:0] pay_full;

    logic id_last;
    logic len_last;
    logic pay_last;
    logic run_hit;

    logic done;
    logic load;
    logic drop;
    logic err_set;
    logic start;

    function automatic logic [lg_els_p-1:0] put_id(
        input logic [lg_els_p-1:0] v,
        input logic [cnt_w-1:0]    idx,
        input logic                b
    );
        logic [lg_els_p-1:0] r;
        r = v;
        for (int i = 0; i < lg_els_p; i++) begin
            if (int'(idx) == i) r[i] = b;
        end
        return r;
    endfunction

    function automatic logic [lg_width_p-1:0] put_len(
        input logic [lg_width_p-1:0] v,
        input logic [cnt_w-1:0]      idx,
        input logic                  b
    );
        logic [lg_width_p-1:0] r;
        r = v;
        for (int i = 0; i < lg_width_p; i++) begin
            if (int'(idx) == i) r[i] = b;
        end
        return r;
    endfunction

    // Payload bits beyond the register width fall through the loop unmatched,
    // which is how over-long payloads are truncated.
    function automatic logic [max_payload_width_p-1:0] put_pay(
        input logic [max_payload_width_p-1:0] v,
        input logic [cnt_w-1:0]               idx,
        input logic                           b
    );
        logic [max_payload_width_p-1:0] r;
        r = v;
        for (int i = 0; i < max_payload_width_p; i++) begin
            if (int'(idx) == i) r[i] = b;
        end
        return r;
    endfunction

    assign len_full = put_len(len_sh, cnt, data_i);
    assign pay_full = put_pay(pay_sh, cnt, data_i);

    assign id_last  = (cnt == cnt_w'(lg_els_p - 1));
    assign len_last = (cnt == cnt_w'(lg_width_p - 1));
    assign pay_last = (({1'b0, cnt} + (cnt_w + 1)'(1)) == (cnt_w + 1)'(len_sh));

    // The consumed bit is the reset_run_p-th one in a row; saturation keeps
    // this from firing again until a zero breaks the run.
    assign run_hit = en_i && data_i && (ones == run_w'(reset_run_p - 1));

    // State register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state <= WAIT_ZERO;
        else            state <= state_next;
    end

    // Next-state decode; a line reset overrides every field transition.
    always_comb begin
        state_next = state;
        if (en_i) begin
            if (run_hit) begin
                state_next = WAIT_ZERO;
            end else begin
                case (state)
                    WAIT_ZERO: if (!data_i) state_next = IDLE;
                    IDLE:      if (data_i)  state_next = ID;
                    ID:        if (id_last) state_next = DNR;
                    DNR:                    state_next = LEN;
                    LEN: begin
                        if (len_last) state_next = (len_full != '0) ? PAYLOAD : IDLE;
                    end
                    PAYLOAD:   if (pay_last) state_next = IDLE;
                    default:                state_next = WAIT_ZERO;
                endcase
            end
        end
    end

    // Completion, hand-off and status decode for the current bit.
    always_comb begin
        done    = 1'b0;
        err_set = 1'b0;
        start   = 1'b0;
        if (en_i && !run_hit) begin
            case (state)
                IDLE:    start = data_i;
                LEN: begin
                    if (len_last) begin
                        done    = (len_full == '0);
                        err_set = (int'(len_full) > max_payload_width_p);
                    end
                end
                PAYLOAD: done = pay_last;
                default: ;
            endcase
        end
        // A slot frees up either because nothing is held or because the held
        // packet is handed off on this very edge.
        load = done && (!v_o || ready_i);
        drop = done && v_o && !ready_i;
    end

    // Bit counters and packet assembly.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt    <= '0;
            ones   <= '0;
            id_sh  <= '0;
            dnr_sh <= 1'b0;
            len_sh <= '0;
            pay_sh <= '0;
        end else if (en_i) begin
            if (!data_i)                          ones <= '0;
            else if (ones != run_w'(reset_run_p)) ones <= ones + run_w'(1);

            if ((state_next == state) &&
                (state == ID || state == LEN || state == PAYLOAD))
                cnt <= cnt + cnt_w'(1);
            else
                cnt <= '0;

            if (start) begin
                id_sh  <= '0;
                dnr_sh <= 1'b0;
                len_sh <= '0;
                pay_sh <= '0;
            end else if (!run_hit) begin
                case (state)
                    ID:      id_sh  <= put_id(id_sh, cnt, data_i);
                    DNR:     dnr_sh <= data_i;
                    LEN:     len_sh <= len_full;
                    PAYLOAD: pay_sh <= pay_full;
                    default: ;
                endcase
            end
        end
    end

    // Output holding register with valid/ready hand-off and sticky status.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v_o              <= 1'b0;
            node_id_o        <= '0;
            data_not_reset_o <= 1'b0;
            len_o            <= '0;
            payload_o        <= '0;
            line_reset_o     <= 1'b0;
            overflow_o       <= 1'b0;
            error_o          <= 1'b0;
        end else begin
            line_reset_o <= run_hit;
            if (drop)    overflow_o <= 1'b1;
            if (err_set) error_o    <= 1'b1;

            if (load) begin
                v_o              <= 1'b1;
                node_id_o        <= id_sh;
                data_not_reset_o <= dnr_sh;
                len_o            <= (state == LEN) ? len_full : len_sh;
                payload_o        <= (state == PAYLOAD) ? pay_full : pay_sh;
            end else if (v_o && ready_i) begin
                v_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bsg_tag_packet_decoder.sv
// Self-checking bench for bsg_tag_packet_decoder (default parameters).
module tb_bsg_tag_packet_decoder;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        en_i;
    logic        data_i;
    logic        v_o;
    logic        ready_i;
    logic [8:0]  node_id_o;
    logic        data_not_reset_o;
    logic [3:0]  len_o;
    logic [9:0]  payload_o;
    logic        line_reset_o;
    logic        overflow_o;
    logic        error_o;

    int n_cmp = 0;
    int n_bad = 0;
    int hs_count = 0;
    int lr_count = 0;

    bsg_tag_packet_decoder dut (
        .clk_i            (clk_i),
        .reset_n_i        (reset_n_i),
        .en_i             (en_i),
        .data_i           (data_i),
        .v_o              (v_o),
        .ready_i          (ready_i),
        .node_id_o        (node_id_o),
        .data_not_reset_o (data_not_reset_o),
        .len_o            (len_o),
        .payload_o        (payload_o),
        .line_reset_o     (line_reset_o),
        .overflow_o       (overflow_o),
        .error_o          (error_o)
    );

    always #5 clk_i = ~clk_i;

    // Count hand-offs and line-reset pulses mid-cycle.
    always @(negedge clk_i) begin
        if (v_o && ready_i) hs_count <= hs_count + 1;
        if (line_reset_o)   lr_count <= lr_count + 1;
    end

    typedef struct {
        logic [8:0]  id;
        logic        dnr;
        logic [3:0]  len;
        logic [15:0] pay;
        logic [9:0]  exp_pay;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present one bit; with gaps, random disabled cycles carrying junk data come first.
    task automatic send_bit(input logic b, input bit gaps);
        if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
                en_i   = 1'b0;
                data_i = 1'($urandom);
                tick();
            end
        end
        en_i   = 1'b1;
        data_i = b;
        tick();
        en_i   = 1'b0;
        data_i = 1'b0;
    endtask

    // One idle zero, then a full packet.
    task automatic send_packet(input logic [8:0] id, input logic dnr, input logic [3:0] len,
                               input logic [15:0] pay, input bit gaps);
        send_bit(1'b0, gaps);
        send_bit(1'b1, gaps);
        for (int i = 0; i < 9; i++) send_bit(id[i], gaps);
        send_bit(dnr, gaps);
        for (int i = 0; i < 4; i++) send_bit(len[i], gaps);
        for (int i = 0; i < 16; i++) if (i < int'(len)) send_bit(pay[i], gaps);
    endtask

    // Fields right after the completing edge, then the hand-off (ready_i=1).
    task automatic check_pkt(input string tag, input int h0, input logic [8:0] id,
                             input logic dnr, input logic [3:0] len,
                             input logic [9:0] exp_pay, input logic exp_err);
        check({tag, " v_o"}, 32'(v_o), 32'd1);
        check({tag, " node_id"}, 32'(node_id_o), 32'(id));
        check({tag, " dnr"}, 32'(data_not_reset_o), 32'(dnr));
        check({tag, " len"}, 32'(len_o), 32'(len));
        check({tag, " payload"}, 32'(payload_o), 32'(exp_pay));
        check({tag, " error"}, 32'(error_o), 32'(exp_err));
        tick();
        check({tag, " v_o drop"}, 32'(v_o), 32'd0);
        check({tag, " pulses"}, 32'(hs_count - h0), 32'd1);
    endtask

    initial begin
        int h0;
        int l0;
        logic        err_exp;
        logic [8:0]  rid;
        logic        rdnr;
        logic [3:0]  rlen;
        logic [15:0] rpay;
        logic [9:0]  rexp;

        // id, dnr, len, payload sent, payload expected, sticky error expected
        vecs[0] = '{9'h005, 1'b1, 4'd3,  16'h0005, 10'h005, 1'b0};
        vecs[1] = '{9'h1FF, 1'b0, 4'd0,  16'h0000, 10'h000, 1'b0};
        vecs[2] = '{9'h000, 1'b1, 4'd10, 16'h03FF, 10'h3FF, 1'b0};
        vecs[3] = '{9'h0AA, 1'b1, 4'd12, 16'h0FFF, 10'h3FF, 1'b1};
        vecs[4] = '{9'h123, 1'b0, 4'd5,  16'hFFFF, 10'h01F, 1'b1};
        vecs[5] = '{9'h0F0, 1'b1, 4'd7,  16'h1234, 10'h034, 1'b1};

        reset_n_i = 1'b0;
        en_i      = 1'b0;
        data_i    = 1'b0;
        ready_i   = 1'b1;
        tick();
        tick();
        tick();
        check("rst v_o", 32'(v_o), 32'd0);
        check("rst line_reset", 32'(line_reset_o), 32'd0);
        check("rst overflow", 32'(overflow_o), 32'd0);
        check("rst error", 32'(error_o), 32'd0);
        check("rst node_id", 32'(node_id_o), 32'd0);
        check("rst dnr", 32'(data_not_reset_o), 32'd0);
        check("rst len", 32'(len_o), 32'd0);
        check("rst payload", 32'(payload_o), 32'd0);
        reset_n_i = 1'b1;

        // Table of single packets, consumer always ready.
        for (int k = 0; k < 6; k++) begin
            h0 = hs_count;
            send_packet(vecs[k].id, vecs[k].dnr, vecs[k].len, vecs[k].pay, 1'b0);
            check_pkt($sformatf("vec%0d", k), h0, vecs[k].id, vecs[k].dnr, vecs[k].len,
                      vecs[k].exp_pay, vecs[k].exp_err);
        end
        check("no overflow yet", 32'(overflow_o), 32'd0);

        // Back-pressure: the second packet must be dropped.
        ready_i = 1'b0;
        send_packet(9'h011, 1'b1, 4'd2, 16'h0002, 1'b0);
        check("hold A v_o", 32'(v_o), 32'd1);
        send_packet(9'h022, 1'b0, 4'd1, 16'h0001, 1'b0);
        check("hold v_o", 32'(v_o), 32'd1);
        check("hold node_id", 32'(node_id_o), 32'h011);
        check("hold len", 32'(len_o), 32'd2);
        check("hold payload", 32'(payload_o), 32'd2);
        check("hold dnr", 32'(data_not_reset_o), 32'd1);
        check("overflow set", 32'(overflow_o), 32'd1);
        h0 = hs_count;
        ready_i = 1'b1;
        tick();
        check("release v_o", 32'(v_o), 32'd0);
        tick();
        tick();
        check("B never shown", 32'(node_id_o), 32'h011);
        check("release pulses", 32'(hs_count - h0), 32'd1);
        check("overflow sticky", 32'(overflow_o), 32'd1);

        // Line reset: 64 ones starting inside the id field. A run of ones also
        // frames complete all-ones packets (start + 9 id + dnr + len=15 +
        // 15 payload = 30 bits): the first one in flight finishes on one #27,
        // the next spans #28..#57, and the third is aborted at #64.
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        h0 = hs_count;
        l0 = lr_count;
        for (int i = 0; i < 63; i++) send_bit(1'b1, 1'b0);
        check("lr before run end", 32'(lr_count - l0), 32'd0);
        send_bit(1'b1, 1'b0);
        check("lr pulse", 32'(line_reset_o), 32'd1);
        send_bit(1'b1, 1'b0);
        check("lr one cycle", 32'(line_reset_o), 32'd0);
        for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b0);
        tick();
        check("lr count", 32'(lr_count - l0), 32'd1);
        check("lr completions", 32'(hs_count - h0), 32'd2);
        check("lr no v_o", 32'(v_o), 32'd0);
        h0 = hs_count;
        send_packet(9'h155, 1'b1, 4'd4, 16'h000A, 1'b0);
        check_pkt("after lr", h0, 9'h155, 1'b1, 4'd4, 10'h00A, 1'b1);

        // Asynchronous reset with a packet held and another in flight.
        ready_i = 1'b0;
        send_packet(9'h0C3, 1'b0, 4'd2, 16'h0001, 1'b0);
        check("pre-rst v_o", 32'(v_o), 32'd1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        #3;
        reset_n_i = 1'b0;
        #1;
        check("async v_o", 32'(v_o), 32'd0);
        check("async node_id", 32'(node_id_o), 32'd0);
        check("async payload", 32'(payload_o), 32'd0);
        check("async overflow", 32'(overflow_o), 32'd0);
        check("async error", 32'(error_o), 32'd0);
        tick();
        reset_n_i = 1'b1;
        ready_i   = 1'b1;
        h0 = hs_count;
        send_packet(9'h0AB, 1'b0, 4'd3, 16'h0006, 1'b0);
        check_pkt("post-rst", h0, 9'h0AB, 1'b0, 4'd3, 10'h006, 1'b0);

        // Same packet as vec0, with random idle enable cycles.
        h0 = hs_count;
        send_packet(9'h005, 1'b1, 4'd3, 16'h0005, 1'b1);
        check_pkt("gaps vec0", h0, 9'h005, 1'b1, 4'd3, 10'h005, 1'b0);

        // Random packets against the packet-level model.
        err_exp = 1'b0;
        for (int k = 0; k < 40; k++) begin
            rid  = 9'($urandom_range(0, 511));
            rdnr = 1'($urandom);
            rlen = 4'($urandom_range(0, 15));
            rpay = 16'($urandom);
            rexp = 10'(32'(rpay) & ((32'd1 << rlen) - 32'd1));
            if (int'(rlen) > 10) err_exp = 1'b1;
            h0 = hs_count;
            send_packet(rid, rdnr, rlen, rpay, 1'b1);
            check_pkt($sformatf("rnd%0d", k), h0, rid, rdnr, rlen, rexp, err_exp);
        end
        check("rnd overflow", 32'(overflow_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
